shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal shift register, the next generation of the team's 4-bit serial-in/parallel-out register. It adds configurable width, bidirectional shifting, synchronous parallel load, hold, serial outputs at both ends and a frame-complete strobe. It sits between bit-serial links and word-wide datapath logic, in both deserialiser and serialiser roles.

## Interface
- WIDTH, 4, register width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), width of the internal shift counter (localparam, not overridable).

- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sir  input  1  serial in for right shift; enters at bit WIDTH-1.
- sil  input  1  serial in for left shift; enters at bit 0.
- pi  input  WIDTH  parallel load data.
- po  output  WIDTH  register contents.
- sor  output  1  po[0], combinational from the register (bit leaving on right shift).
- sol  output  1  po[WIDTH-1], combinational from the register (bit leaving on left shift).
- frame_valid  output  1  one-cycle strobe: WIDTH consecutive same-direction shifts completed.

## Operation
- Reset values: po = 0, frame_valid = 0, counter = 0, last direction = right.
- rst has priority over mode on the same edge.
- Register update per edge:
  - 00: po unchanged.
  - 01: po <= {sir, po[WIDTH-1:1]}.
  - 10: po <= {po[WIDTH-2:0], sil}.
  - 11: po <= pi.
- Shift counter, counting shifts since the last frame boundary:
  - Load (11): counter <= 0.
  - Hold (00): counter unchanged. Hold cycles do not break a frame.
  - Shift in the same direction as the last shift: counter <= counter + 1.
  - Shift in the opposite direction: counter <= 1. The shift that changes direction counts as the first of a new frame. The last direction is then updated.
  - If the shift brings the counter to WIDTH, the counter wraps to 0 on that edge.
- frame_valid is registered.
  - It is 1 for exactly the cycle after the edge on which the counter reached WIDTH; otherwise 0.
  - It is never asserted by a load or by a hold.
  - Back-to-back frames strobe once every WIDTH shift cycles, with no gap cycle needed.
- Arithmetic: the counter never exceeds WIDTH, and CW bits hold WIDTH exactly.
- sor and sol always reflect the current po. They carry no extra register stage.

## Timing
- Latency: a serial bit sampled on edge N is visible in po after edge N.
- frame_valid rises after the same edge that shifts in the WIDTH-th bit, so po already holds the complete frame while frame_valid = 1.
- Parallel load: pi sampled on edge N appears on po, sor and sol after edge N.
- Reset mid-frame: the edge with rst = 1 clears po and the counter and forces frame_valid = 0, including when a frame would have completed on that edge.
- Inputs must be stable around the rising edge of clk. There is no clock enable; mode 00 serves as the stall.

## Test plan
- Reset: hold rst = 1 for 2 edges with mode = 01, sir = 1 -> po = 0, frame_valid = 0 throughout; no shift occurs.
- Right deserialise (WIDTH = 4): from 0, mode = 01, sir = 1,1,0,1 -> po = 1000, 1100, 0110, 1011; frame_valid = 1 only in the cycle po = 1011; sor = 1, sol = 1 there.
- Left shift with hold gap: from 0, mode = 10, sil = 1,0 then mode = 00 for 3 cycles, then sil = 1,1 -> po = 0001, 0010, 0010 (x3), 0101, 1011; frame_valid = 1 only with po = 1011.
- Load and serialise out: mode = 11, pi = 1010 -> po = 1010, sor = 0. Then 4 right shifts with sir = 0 -> sor = 1, 0, 1, 0 on successive cycles, po = 0000 at end, frame_valid = 1 after the 4th shift.
- Direction change: 2 right shifts, then 4 left shifts -> no strobe after the 2nd left shift; frame_valid = 1 after the 4th left shift only.
- Reset mid-frame and back-to-back frames: assert rst on the 3rd of 4 right shifts -> po = 0, no strobe. Then 8 continuous right shifts -> frame_valid = 1 after shift 4 and after shift 8 only.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, bidirectional shift, parallel load, serial outputs at both
// ends and a one-cycle strobe after WIDTH consecutive shifts in the same direction.
module shift_reg_univ #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             sir,
    input  logic             sil,
    input  logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] po,
    output logic             sor,
    output logic             sol,
    output logic             frame_valid
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    mode_e           mode_w;
    logic [WIDTH-1:0] po_q, po_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    dir_e             dir_q, dir_d, shift_dir;
    logic             fv_q, fv_d;
    logic             is_shift;

    assign mode_w = mode_e'(mode);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        po_d      = po_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        fv_d      = 1'b0;
        is_shift  = 1'b0;
        shift_dir = dir_q;
        cnt_inc   = '0;

        case (mode_w)
            MODE_SHR: begin
                po_d      = {sir, po_q[WIDTH-1:1]};
                is_shift  = 1'b1;
                shift_dir = DIR_RIGHT;
            end
            MODE_SHL: begin
                po_d      = {po_q[WIDTH-2:0], sil};
                is_shift  = 1'b1;
                shift_dir = DIR_LEFT;
            end
            MODE_LOAD: begin
                po_d  = pi;
                cnt_d = '0;
            end
            default: ;
        endcase

        // A direction change starts a new frame with this shift as its first bit.
        if (is_shift) begin
            cnt_inc = (shift_dir == dir_q) ? cnt_q + CW'(1) : CW'(1);
            dir_d   = shift_dir;
            if (cnt_inc == CW'(WIDTH)) begin
                cnt_d = '0;
                fv_d  = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            po_q  <= '0;
            cnt_q <= '0;
            dir_q <= DIR_RIGHT;
            fv_q  <= 1'b0;
        end else begin
            po_q  <= po_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            fv_q  <= fv_d;
        end
    end

    assign po          = po_q;
    assign sor         = po_q[0];
    assign sol         = po_q[WIDTH-1];
    assign frame_valid = fv_q;

    // The counter wraps on reaching WIDTH, so between edges it stays strictly below it.
    cnt_in_range: assert property (@(posedge clk) disable iff (rst) cnt_q < CW'(WIDTH));

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_shift_reg_univ;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   mode = 2'b00;
    logic         sir = 1'b0;
    logic         sil = 1'b0;
    logic [W-1:0] pi = '0;
    logic [W-1:0] po;
    logic         sor;
    logic         sol;
    logic         frame_valid;

    int tests_run = 0;
    int failed    = 0;

    // Behavioural model: register value as plain arithmetic, and the directions of the
    // shifts in the current frame kept as a queue (a frame is W equal entries).
    logic [W-1:0] m_po = '0;
    logic         m_fv = 1'b0;
    bit           m_run[$];

    shift_reg_univ #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .sir         (sir),
        .sil         (sil),
        .pi          (pi),
        .po          (po),
        .sor         (sor),
        .sol         (sol),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    task automatic model_shift(input bit dir);
        if (m_run.size() > 0 && m_run[$] != dir) m_run.delete();
        m_run.push_back(dir);
        if (m_run.size() == W) begin
            m_fv = 1'b1;
            m_run.delete();
        end else begin
            m_fv = 1'b0;
        end
    endtask

    task automatic model_update(input logic r, input logic [1:0] m, input logic si_r,
                                input logic si_l, input logic [W-1:0] p);
        if (r) begin
            m_po = '0;
            m_fv = 1'b0;
            m_run.delete();
        end else begin
            case (m)
                2'b01: begin
                    m_po = (m_po >> 1) | (W'(si_r) << (W - 1));
                    model_shift(1'b0);
                end
                2'b10: begin
                    m_po = (m_po << 1) | W'(si_l);
                    model_shift(1'b1);
                end
                2'b11: begin
                    m_po = p;
                    m_fv = 1'b0;
                    m_run.delete();
                end
                default: m_fv = 1'b0;
            endcase
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic drive(input logic r, input logic [1:0] m, input logic si_r,
                         input logic si_l, input logic [W-1:0] p);
        @(negedge clk);
        rst  = r;
        mode = m;
        sir  = si_r;
        sil  = si_l;
        pi   = p;
        @(posedge clk);
        #1;
        model_update(r, m, si_r, si_l, p);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b01, 1'b1, 1'b0, '0);
            tests_run++;
            if (po !== 4'b0000) begin
                failed++;
                $display("FAIL reset_po[%0d]: got %b expected 0000", i, po);
            end
            tests_run++;
            if (frame_valid !== 1'b0) begin
                failed++;
                $display("FAIL reset_fv[%0d]: got %b expected 0", i, frame_valid);
            end
        end
    endtask

    task automatic test_right_deser;
        logic         bits   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] exp_po [4] = '{4'b1000, 4'b1100, 4'b0110, 4'b1011};
        logic         exp_fv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b01, bits[i], 1'b0, '0);
            tests_run++;
            if (po !== exp_po[i]) begin
                failed++;
                $display("FAIL right_deser_po[%0d]: got %b expected %b", i, po, exp_po[i]);
            end
            tests_run++;
            if (frame_valid !== exp_fv[i]) begin
                failed++;
                $display("FAIL right_deser_fv[%0d]: got %b expected %b", i, frame_valid, exp_fv[i]);
            end
        end
        tests_run++;
        if (sor !== 1'b1 || sol !== 1'b1) begin
            failed++;
            $display("FAIL right_deser_serial_out: got sor=%b sol=%b expected sor=1 sol=1", sor, sol);
        end
    endtask

    task automatic test_left_hold_gap;
        logic [1:0]   modes  [7] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
        logic         bits   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] exp_po [7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0101, 4'b1011};
        drive(1'b1, 2'b00, 1'b0, 1'b0, '0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, modes[i], 1'b0, bits[i], '0);
            tests_run++;
            if (po !== exp_po[i]) begin
                failed++;
                $display("FAIL left_hold_po[%0d]: got %b expected %b", i, po, exp_po[i]);
            end
            tests_run++;
            if (frame_valid !== (i == 6)) begin
                failed++;
                $display("FAIL left_hold_fv[%0d]: got %b expected %b", i, frame_valid, (i == 6));
            end
        end
    endtask

    task automatic test_load_serialise;
        logic         exp_sor [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] exp_po  [4] = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
        drive(1'b0, 2'b11, 1'b0, 1'b0, 4'b1010);
        tests_run++;
        if (po !== 4'b1010 || sor !== 1'b0 || sol !== 1'b1 || frame_valid !== 1'b0) begin
            failed++;
            $display("FAIL load: got po=%b sor=%b sol=%b fv=%b expected po=1010 sor=0 sol=1 fv=0",
                     po, sor, sol, frame_valid);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b01, 1'b0, 1'b0, '0);
            tests_run++;
            if (sor !== exp_sor[i] || po !== exp_po[i]) begin
                failed++;
                $display("FAIL serialise[%0d]: got sor=%b po=%b expected sor=%b po=%b",
                         i, sor, po, exp_sor[i], exp_po[i]);
            end
            tests_run++;
            if (frame_valid !== (i == 3)) begin
                failed++;
                $display("FAIL serialise_fv[%0d]: got %b expected %b", i, frame_valid, (i == 3));
            end
        end
    endtask

    task automatic test_direction_change;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, (i < 2) ? 2'b01 : 2'b10, 1'($urandom), 1'($urandom), '0);
            tests_run++;
            if (frame_valid !== (i == 5)) begin
                failed++;
                $display("FAIL dir_change_fv[%0d]: got %b expected %b", i, frame_valid, (i == 5));
            end
            tests_run++;
            if (po !== m_po) begin
                failed++;
                $display("FAIL dir_change_po[%0d]: got %b expected %b", i, po, m_po);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        // Reset on the edge that would complete a frame.
        for (int i = 0; i < 4; i++) drive(i == 3, 2'b01, 1'b1, 1'b0, '0);
        tests_run++;
        if (po !== 4'b0000 || frame_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_on_complete: got po=%b fv=%b expected po=0000 fv=0", po, frame_valid);
        end
        // Reset on the third of four shifts.
        for (int i = 0; i < 3; i++) drive(i == 2, 2'b01, 1'b1, 1'b0, '0);
        tests_run++;
        if (po !== 4'b0000 || frame_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_frame: got po=%b fv=%b expected po=0000 fv=0", po, frame_valid);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'b01, 1'($urandom), 1'b0, '0);
            tests_run++;
            if (frame_valid !== (i == 3 || i == 7)) begin
                failed++;
                $display("FAIL back_to_back_fv[%0d]: got %b expected %b", i, frame_valid, (i == 3 || i == 7));
            end
            tests_run++;
            if (po !== m_po) begin
                failed++;
                $display("FAIL back_to_back_po[%0d]: got %b expected %b", i, po, m_po);
            end
        end
    endtask

    task automatic test_random;
        logic         r;
        logic [1:0]   m;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(31) == 0);
            m = 2'($urandom);
            drive(r, m, 1'($urandom), 1'($urandom), W'($urandom));
            tests_run++;
            if (po !== m_po || sor !== m_po[0] || sol !== m_po[W-1] || frame_valid !== m_fv) begin
                failed++;
                $display("FAIL random[%0d]: got po=%b sor=%b sol=%b fv=%b expected po=%b sor=%b sol=%b fv=%b",
                         i, po, sor, sol, frame_valid, m_po, m_po[0], m_po[W-1], m_fv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_right_deser();
        test_left_hold_gap();
        test_load_serialise();
        test_direction_change();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
